msx_io_port_decoder: RTL

//  Parametrised MSX cartridge I/O decoder for NUM_CH consecutive Z80 I/O ports starting at BASE_ADDR.

---
 rtl/msx_io_port_decoder_if.sv | 33 +++
 rtl/msx_io_port_decoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/msx_io_port_decoder_if.sv
// ============================================================================
// msx_io_port_decoder_if : MSX slot-side I/O bus bundle for the port decoder
// Rev 1.0
// ============================================================================
`default_nettype none

interface msx_io_port_decoder_if #(
  parameter int NUM_CH = 4
);
  logic [7:0]        address_bus;
  logic              iorq_n;
  logic              rd_n;
  logic              wr_n;
  logic              m1_n;
  logic [NUM_CH-1:0] cs_n;
  logic              busdir;
  logic [NUM_CH-1:0] rd_stb;
  logic [NUM_CH-1:0] wr_stb;
  logic [2:0]        ch_idx;
  logic              wait_n;

  modport master (
    output address_bus, iorq_n, rd_n, wr_n, m1_n,
    input  cs_n, busdir, rd_stb, wr_stb, ch_idx, wait_n
  );

  modport slave (
    input  address_bus, iorq_n, rd_n, wr_n, m1_n,
    output cs_n, busdir, rd_stb, wr_stb, ch_idx, wait_n
  );
endinterface

`default_nettype wire

// File: rtl/msx_io_port_decoder.sv
// ============================================================================
// msx_io_port_decoder : NUM_CH-port MSX I/O decoder with one-clk strobes and a
// Z80 WAIT generator built only when MSX_IO_WAIT_EN is defined.   Rev 1.0
// ============================================================================
`default_nettype none

module msx_io_port_decoder #(
  parameter logic [7:0] BASE_ADDR   = 8'h10,
  parameter int         NUM_CH      = 4,
  parameter int         WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  msx_io_port_decoder_if.slave    bus
);

  if (NUM_CH < 1 || NUM_CH > 8 || WAIT_CYCLES < 0 || WAIT_CYCLES > 15 ||
      (int'(BASE_ADDR) + NUM_CH) > 256) begin : g_bad_params
    $error("msx_io_port_decoder: parameter out of range");
  end

  localparam logic [8:0] c_base = {1'b0, BASE_ADDR};
  localparam logic [8:0] c_end  = c_base + 9'(NUM_CH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  function automatic logic [NUM_CH-1:0] f_onehot(input logic [2:0] idx);
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = (idx == 3'(i));
    return v;
  endfunction

  logic [8:0]        w_addr_ext;
  logic              w_in_range;
  logic              w_hit;
  logic [2:0]        w_idx;
  logic              w_iorq_fall;
  logic              w_rd_low;
  logic              w_wr_low;
  logic              w_start;

  state_t            r_state;
  logic [3:0]        r_sync1;     // {m1_n, wr_n, rd_n, iorq_n}
  logic [3:0]        r_sync2;
  logic              r_iorq_d;
  logic [NUM_CH-1:0] r_rd_stb;
  logic [NUM_CH-1:0] r_wr_stb;
  logic [2:0]        r_ch_idx;
`ifdef MSX_IO_WAIT_EN
  logic              r_wait_n;
  logic [3:0]        r_wait_cnt;
  logic              r_is_read;
`endif

  // Raw-bus decode: the Z80 sees cs_n/busdir without any clock latency.
  assign w_addr_ext = {1'b0, bus.address_bus};
  assign w_in_range = (w_addr_ext >= c_base) && (w_addr_ext < c_end);
  assign w_hit      = ~bus.iorq_n & bus.m1_n & w_in_range;
  assign w_idx      = 3'(bus.address_bus - BASE_ADDR);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cs
    assign bus.cs_n[i] = ~(w_hit && (w_idx == 3'(i)));
  end

  assign bus.busdir = ~(w_hit & ~bus.rd_n);

  assign w_iorq_fall = r_iorq_d & ~r_sync2[0];
  assign w_rd_low    = ~r_sync2[1];
  assign w_wr_low    = ~r_sync2[2];
  assign w_start     = w_iorq_fall & r_sync2[3] & w_in_range;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_iorq_d   <= 1'b1;
      r_rd_stb   <= '0;
      r_wr_stb   <= '0;
      r_ch_idx   <= '0;
`ifdef MSX_IO_WAIT_EN
      r_wait_n   <= 1'b1;
      r_wait_cnt <= '0;
      r_is_read  <= 1'b0;
`endif
    end else begin
      r_sync1  <= {bus.m1_n, bus.wr_n, bus.rd_n, bus.iorq_n};
      r_sync2  <= r_sync1;
      r_iorq_d <= r_sync2[0];
      r_rd_stb <= '0;
      r_wr_stb <= '0;

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_ch_idx <= w_idx;
            // Ambiguous direction: swallow the whole IORQ cycle without a strobe.
            if (w_rd_low == w_wr_low) begin
              r_state <= ST_HOLD;
            end
`ifdef MSX_IO_WAIT_EN
            else if (WAIT_CYCLES > 0) begin
              r_state    <= ST_WAIT;
              r_wait_n   <= 1'b0;
              r_wait_cnt <= 4'(WAIT_CYCLES - 1);
              r_is_read  <= w_rd_low;
            end
`endif
            else begin
              r_state  <= ST_STROBE;
              r_rd_stb <= w_rd_low ? f_onehot(w_idx) : '0;
              r_wr_stb <= w_wr_low ? f_onehot(w_idx) : '0;
            end
          end
        end
        ST_WAIT: begin
`ifdef MSX_IO_WAIT_EN
          if (r_sync2[0]) begin
            r_state  <= ST_IDLE;
            r_wait_n <= 1'b1;
          end else if (r_wait_cnt == 4'd0) begin
            r_state  <= ST_STROBE;
            r_wait_n <= 1'b1;
            r_rd_stb <= r_is_read  ? f_onehot(r_ch_idx) : '0;
            r_wr_stb <= !r_is_read ? f_onehot(r_ch_idx) : '0;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
`else
          r_state <= ST_IDLE;
`endif
        end
        ST_STROBE: r_state <= ST_HOLD;
        ST_HOLD: begin
          if (r_sync2[0]) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_stb = r_rd_stb;
  assign bus.wr_stb = r_wr_stb;
  assign bus.ch_idx = r_ch_idx;
`ifdef MSX_IO_WAIT_EN
  assign bus.wait_n = r_wait_n;
`else
  assign bus.wait_n = 1'b1;
`endif

endmodule

`default_nettype wire
